// File: rtl/window_fetcher_if.sv
// window_fetcher_if: request, memory-read and window buses of the KxK window fetcher.
// start_*: centre request (valid/ready, row, col, mode).
// rd_*: image memory read port (rd_data arrives one cycle after rd_en).
// win_*: flat KxK window output (valid/ready, data, slid flag).
// slave is the fetcher side, master is the requester/memory/consumer side.
interface window_fetcher_if #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int K      = 3
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    logic                     start_valid;
    logic                     start_ready;
    logic [ROW_W-1:0]         start_row;
    logic [COL_W-1:0]         start_col;
    logic                     start_mode;
    logic                     rd_en;
    logic [ROW_W+COL_W-1:0]   rd_addr;
    logic [DATA_W-1:0]        rd_data;
    logic                     win_valid;
    logic                     win_ready;
    logic [K*K*DATA_W-1:0]    win_data;
    logic                     win_slid;
    modport slave (
        input  start_valid, start_row, start_col, start_mode, rd_data, win_ready,
        output start_ready, rd_en, rd_addr, win_valid, win_data, win_slid
    );
    modport master (
        output start_valid, start_row, start_col, start_mode, rd_data, win_ready,
        input  start_ready, rd_en, rd_addr, win_valid, win_data, win_slid
    );
endinterface

// File: rtl/window_fetcher.sv
// window_fetcher: fetches a zero-padded KxK neighbourhood around a centre pixel, reusing taps on a one-column slide.
// clk, rst_n: clock and asynchronous active-low reset.
// bus (slave): start_* centre request in, rd_* memory read port, win_* flat window out.
module window_fetcher #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int K      = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    window_fetcher_if.slave bus
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int KW    = $clog2(K);
    localparam int TW    = $clog2(K*K);
    localparam int HK    = K / 2;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, VALID} state_t;
    state_t                     state_q, state_d;
    logic [ROW_W-1:0]           row_q, row_d, prev_row_q, prev_row_d;
    logic [COL_W-1:0]           col_q, col_d, prev_col_q, prev_col_d;
    logic                       prev_valid_q, prev_valid_d, slid_q, slid_d;
    logic                       cap_q, cap_d, pad_q, pad_d;
    logic [KW-1:0]              r_q, r_d, c_q, c_d;
    logic [TW-1:0]              idx_q, idx_d;
    logic [K*K-1:0][DATA_W-1:0] win_q, win_d;
    logic [ROW_W+1:0]           tr;
    logic [COL_W+1:0]           tc;
    logic                       in_img, slide, last;
    // Two extra bits hold the sign and the overflow past the image edge,
    // so a tap is inside the image exactly when both top bits are clear.
    assign tr     = {2'b00, row_q} + (ROW_W+2)'(r_q) - (ROW_W+2)'(HK);
    assign tc     = {2'b00, col_q} + (COL_W+2)'(c_q) - (COL_W+2)'(HK);
    assign in_img = (tr[ROW_W+1:ROW_W] == 2'b00) && (tc[COL_W+1:COL_W] == 2'b00);
    assign slide  = bus.start_mode & prev_valid_q & (bus.start_row == prev_row_q)
                  & ({1'b0, bus.start_col} == {1'b0, prev_col_q} + 1'b1);
    assign last   = (r_q == KW'(K-1)) && (c_q == KW'(K-1));
    assign bus.start_ready = state_q == IDLE;
    assign bus.rd_en       = (state_q == FETCH) && in_img;
    assign bus.rd_addr     = bus.rd_en ? {tr[ROW_W-1:0], tc[COL_W-1:0]} : '0;
    assign bus.win_valid   = state_q == VALID;
    assign bus.win_data    = win_q;
    assign bus.win_slid    = slid_q;
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        prev_row_d   = prev_row_q;
        prev_col_d   = prev_col_q;
        prev_valid_d = prev_valid_q;
        slid_d       = slid_q;
        r_d          = r_q;
        c_d          = c_q;
        win_d        = win_q;
        // Tap index and pad flag ride one cycle behind the read to meet rd_data.
        cap_d        = state_q == FETCH;
        pad_d        = ~in_img;
        idx_d        = TW'(r_q * K + c_q);
        if (cap_q)
            win_d[idx_q] = pad_q ? '0 : bus.rd_data;
        case (state_q)
            IDLE: if (bus.start_valid) begin
                state_d = FETCH;
                row_d   = bus.start_row;
                col_d   = bus.start_col;
                slid_d  = slide;
                r_d     = '0;
                c_d     = slide ? KW'(K-1) : '0;
                if (slide)
                    for (int r = 0; r < K; r++)
                        for (int c = 0; c < K-1; c++)
                            win_d[r*K+c] = win_q[r*K+c+1];
            end
            FETCH: if (last) begin
                state_d = DRAIN;
            end else if (slid_q || c_q == KW'(K-1)) begin
                r_d = r_q + 1'b1;
                c_d = slid_q ? c_q : '0;
            end else begin
                c_d = c_q + 1'b1;
            end
            DRAIN: state_d = VALID;
            VALID: if (bus.win_ready) begin
                state_d      = IDLE;
                prev_valid_d = 1'b1;
                prev_row_d   = row_q;
                prev_col_d   = col_q;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            prev_row_q   <= '0;
            prev_col_q   <= '0;
            prev_valid_q <= 1'b0;
            slid_q       <= 1'b0;
            cap_q        <= 1'b0;
            pad_q        <= 1'b0;
            idx_q        <= '0;
            r_q          <= '0;
            c_q          <= '0;
            win_q        <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            prev_row_q   <= prev_row_d;
            prev_col_q   <= prev_col_d;
            prev_valid_q <= prev_valid_d;
            slid_q       <= slid_d;
            cap_q        <= cap_d;
            pad_q        <= pad_d;
            idx_q        <= idx_d;
            r_q          <= r_d;
            c_q          <= c_d;
            win_q        <= win_d;
        end
    end
endmodule

// File: tb/tb_window_fetcher.sv
// tb_window_fetcher: directed self-checking bench for window_fetcher (K=3, 128x128).
module tb_window_fetcher;
    localparam int DW = 8;
    localparam int IW = 128;
    localparam int IH = 128;
    localparam int K  = 3;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    int nreads, lat, zviol;
    logic [13:0] rd_log [16];
    int          rd_cyc [16];
    window_fetcher_if #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .K(K)) bus ();
    window_fetcher #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .K(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    function automatic logic [7:0] pix(input int r, input int c);
        return 8'(r * 13 + c * 5 + 7);
    endfunction
    function automatic logic [13:0] a(input int r, input int c);
        return 14'(r * 128 + c);
    endfunction
    function automatic logic [71:0] exp_win(input int r, input int c);
        logic [71:0] w;
        int tr, tc;
        w = '0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++) begin
                tr = r + dr - 1;
                tc = c + dc - 1;
                if (tr >= 0 && tr < IH && tc >= 0 && tc < IW)
                    w[(dr*3+dc)*8 +: 8] = pix(tr, tc);
            end
        return w;
    endfunction
    // Memory returns data one cycle after the strobe; garbage when not strobed.
    always @(posedge clk)
        bus.rd_data <= bus.rd_en ? pix(int'(bus.rd_addr[13:7]), int'(bus.rd_addr[6:0])) : 8'hEE;
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic run_req(input int r, input int c, input logic m);
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.start_row   = 7'(r);
        bus.start_col   = 7'(c);
        bus.start_mode  = m;
        nreads = 0;
        lat    = -1;
        zviol  = 0;
        @(posedge clk);
        for (int cy = 1; cy <= 40 && lat < 0; cy++) begin
            @(negedge clk);
            bus.start_valid = 1'b0;
            if (bus.rd_en) begin
                if (nreads < 16) begin
                    rd_log[nreads] = bus.rd_addr;
                    rd_cyc[nreads] = cy;
                end
                nreads++;
            end else if (bus.rd_addr != '0) zviol++;
            if (bus.win_valid) lat = cy;
        end
    endtask
    task automatic accept();
        bus.win_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.win_ready = 1'b0;
    endtask
    initial begin
        bus.start_valid = 1'b0;
        bus.start_row   = '0;
        bus.start_col   = '0;
        bus.start_mode  = 1'b0;
        bus.win_ready   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_win_data", bus.win_data, 0);
        chk("rst_rd_en", bus.rd_en, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_start_ready", bus.start_ready, 1);
        chk("rst_win_valid", bus.win_valid, 0);
        chk("rst_win_slid", bus.win_slid, 0);
        chk("rst_rd_addr", bus.rd_addr, 0);
        // Full fetch of an interior centre.
        run_req(5, 5, 1'b1);
        chk("t1_lat", lat, 11);
        chk("t1_nreads", nreads, 9);
        chk("t1_zviol", zviol, 0);
        for (int i = 0; i < 9; i++) begin
            chk("t1_addr", rd_log[i], a(4 + i / 3, 4 + i % 3));
            chk("t1_cyc", rd_cyc[i], i + 1);
        end
        chk("t1_win", bus.win_data, exp_win(5, 5));
        chk("t1_slid", bus.win_slid, 0);
        // Consumer stalls for four cycles.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_valid", bus.win_valid, 1);
            chk("hold_data", bus.win_data, exp_win(5, 5));
            chk("hold_start_ready", bus.start_ready, 0);
        end
        accept();
        chk("idle_hold_data", bus.win_data, exp_win(5, 5));
        // One column to the right: slide.
        run_req(5, 6, 1'b1);
        chk("t4_lat", lat, 5);
        chk("t4_nreads", nreads, 3);
        for (int i = 0; i < 3; i++) begin
            chk("t4_addr", rd_log[i], a(4 + i, 7));
            chk("t4_cyc", rd_cyc[i], i + 1);
        end
        chk("t4_slid", bus.win_slid, 1);
        chk("t4_win", bus.win_data, exp_win(5, 6));
        accept();
        // Jump by two columns, then change row: both full fetches.
        run_req(5, 8, 1'b1);
        chk("t5a_lat", lat, 11);
        chk("t5a_nreads", nreads, 9);
        chk("t5a_slid", bus.win_slid, 0);
        chk("t5a_win", bus.win_data, exp_win(5, 8));
        accept();
        run_req(6, 9, 1'b1);
        chk("t5b_lat", lat, 11);
        chk("t5b_slid", bus.win_slid, 0);
        chk("t5b_win", bus.win_data, exp_win(6, 9));
        accept();
        // Top-left corner.
        run_req(0, 0, 1'b0);
        chk("t2_lat", lat, 11);
        chk("t2_nreads", nreads, 4);
        chk("t2_zviol", zviol, 0);
        chk("t2_c0", rd_cyc[0], 5);
        chk("t2_c1", rd_cyc[1], 6);
        chk("t2_c2", rd_cyc[2], 8);
        chk("t2_c3", rd_cyc[3], 9);
        chk("t2_a0", rd_log[0], a(0, 0));
        chk("t2_a1", rd_log[1], a(0, 1));
        chk("t2_a2", rd_log[2], a(1, 0));
        chk("t2_a3", rd_log[3], a(1, 1));
        chk("t2_win", bus.win_data, exp_win(0, 0));
        accept();
        // Bottom-right corner: no wrap to row 0 or col 0.
        run_req(127, 127, 1'b0);
        chk("t3_lat", lat, 11);
        chk("t3_nreads", nreads, 4);
        chk("t3_a0", rd_log[0], a(126, 126));
        chk("t3_a1", rd_log[1], a(126, 127));
        chk("t3_a2", rd_log[2], a(127, 126));
        chk("t3_a3", rd_log[3], a(127, 127));
        chk("t3_win", bus.win_data, exp_win(127, 127));
        accept();
        run_req(20, 20, 1'b0);
        chk("t6_pre_win", bus.win_data, exp_win(20, 20));
        accept();
        // Reset in the middle of a fetch.
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.start_row   = 7'd20;
        bus.start_col   = 7'd21;
        bus.start_mode  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_c4_rd_en", bus.rd_en, 1);
        chk("t6_c4_addr", bus.rd_addr, a(20, 20));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rd_en", bus.rd_en, 0);
        chk("t6_rst_addr", bus.rd_addr, 0);
        chk("t6_rst_valid", bus.win_valid, 0);
        chk("t6_rst_data", bus.win_data, 0);
        chk("t6_rst_slid", bus.win_slid, 0);
        chk("t6_rst_ready", bus.start_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_req(20, 21, 1'b1);
        chk("t6_lat", lat, 11);
        chk("t6_nreads", nreads, 9);
        chk("t6_slid", bus.win_slid, 0);
        chk("t6_win", bus.win_data, exp_win(20, 21));
        accept();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
